// File: rtl/rmt_input_arbiter.sv
// Packet-level arbiter merging the table-config (control) stream and the data
// stream into one AXI-Stream feeding rmt_wrapper, with a post-config idle gap.
module rmt_input_arbiter #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CFG_GAP              = 8,
  parameter int MAX_CTRL_BURST       = 4,
  parameter int PKT_CNT_W            = 16
) (
  input  logic                              clk,
  input  logic                              aresetn,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_ctrl_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_ctrl_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_ctrl_axis_tuser,
  input  logic                              s_ctrl_axis_tvalid,
  input  logic                              s_ctrl_axis_tlast,
  output logic                              s_ctrl_axis_tready,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_data_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_data_axis_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_data_axis_tuser,
  input  logic                              s_data_axis_tvalid,
  input  logic                              s_data_axis_tlast,
  output logic                              s_data_axis_tready,

  output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  input  logic                              m_axis_tready,

  output logic                              cfg_busy,
  output logic [PKT_CNT_W-1:0]              ctrl_pkt_cnt,
  output logic [PKT_CNT_W-1:0]              data_pkt_cnt
);

  typedef enum logic [1:0] {IDLE, CTRL, DATA, GAP} state_e;

  localparam logic [3:0] MAX_BURST = 4'(MAX_CTRL_BURST);
  localparam logic [7:0] GAP_LOAD  = 8'((CFG_GAP > 0) ? (CFG_GAP - 1) : 0);

  state_e                 state_q, state_d;
  logic [3:0]             burst_cnt_q, burst_cnt_d;
  logic [7:0]             gap_cnt_q, gap_cnt_d;
  logic [PKT_CNT_W-1:0]   ctrl_pkt_cnt_q, ctrl_pkt_cnt_d;
  logic [PKT_CNT_W-1:0]   data_pkt_cnt_q, data_pkt_cnt_d;
  logic                   ctrl_done, data_done;

  assign ctrl_done = (state_q == CTRL) && s_ctrl_axis_tvalid && m_axis_tready && s_ctrl_axis_tlast;
  assign data_done = (state_q == DATA) && s_data_axis_tvalid && m_axis_tready && s_data_axis_tlast;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= IDLE;
      burst_cnt_q    <= 4'd0;
      gap_cnt_q      <= 8'd0;
      ctrl_pkt_cnt_q <= '0;
      data_pkt_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      ctrl_pkt_cnt_q <= ctrl_pkt_cnt_d;
      data_pkt_cnt_q <= data_pkt_cnt_d;
    end
  end

  // Burst counter only advances when control wins while data is waiting, so
  // data gets a turn after MAX_CTRL_BURST consecutive control grants.
  always_comb begin
    state_d        = state_q;
    burst_cnt_d    = burst_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    ctrl_pkt_cnt_d = ctrl_pkt_cnt_q + PKT_CNT_W'(ctrl_done);
    data_pkt_cnt_d = data_pkt_cnt_q + PKT_CNT_W'(data_done);
    unique case (state_q)
      IDLE: begin
        if (s_ctrl_axis_tvalid && (!s_data_axis_tvalid || (burst_cnt_q < MAX_BURST))) begin
          state_d = CTRL;
          if (s_data_axis_tvalid && (burst_cnt_q < MAX_BURST)) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end else if (s_data_axis_tvalid) begin
          state_d     = DATA;
          burst_cnt_d = 4'd0;
        end
      end
      CTRL: begin
        if (ctrl_done) begin
          if (CFG_GAP > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (data_done) begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_axis_tdata       = '0;
    m_axis_tkeep       = '0;
    m_axis_tuser       = '0;
    m_axis_tvalid      = 1'b0;
    m_axis_tlast       = 1'b0;
    s_ctrl_axis_tready = 1'b0;
    s_data_axis_tready = 1'b0;
    unique case (state_q)
      CTRL: begin
        m_axis_tdata       = s_ctrl_axis_tdata;
        m_axis_tkeep       = s_ctrl_axis_tkeep;
        m_axis_tuser       = s_ctrl_axis_tuser;
        m_axis_tvalid      = s_ctrl_axis_tvalid;
        m_axis_tlast       = s_ctrl_axis_tlast;
        s_ctrl_axis_tready = m_axis_tready;
      end
      DATA: begin
        m_axis_tdata       = s_data_axis_tdata;
        m_axis_tkeep       = s_data_axis_tkeep;
        m_axis_tuser       = s_data_axis_tuser;
        m_axis_tvalid      = s_data_axis_tvalid;
        m_axis_tlast       = s_data_axis_tlast;
        s_data_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  assign cfg_busy     = (state_q == CTRL) || (state_q == GAP);
  assign ctrl_pkt_cnt = ctrl_pkt_cnt_q;
  assign data_pkt_cnt = data_pkt_cnt_q;

endmodule

// File: tb/tb_rmt_input_arbiter.sv
// Directed bench for rmt_input_arbiter: u0 uses the default gap, u1 has no gap
// and a narrow packet counter so the wrap can be reached in a few packets.
module tb_rmt_input_arbiter;

  logic clk = 1'b0;
  logic aresetn;
  always #5 clk = ~clk;

  logic [511:0] c_data, d_data;
  logic [63:0]  c_keep, d_keep;
  logic [127:0] c_user, d_user;
  logic         c_valid, c_last, d_valid, d_last, m_tready;

  logic [511:0] m0_tdata, m1_tdata;
  logic [63:0]  m0_tkeep, m1_tkeep;
  logic [127:0] m0_tuser, m1_tuser;
  logic         m0_tvalid, m0_tlast, m1_tvalid, m1_tlast;
  logic         ctr0, dtr0, ctr1, dtr1, busy0, busy1;
  logic [15:0]  cc0, dc0;
  logic [3:0]   cc1, dc1;

  rmt_input_arbiter u0 (
    .clk(clk), .aresetn(aresetn),
    .s_ctrl_axis_tdata(c_data), .s_ctrl_axis_tkeep(c_keep), .s_ctrl_axis_tuser(c_user),
    .s_ctrl_axis_tvalid(c_valid), .s_ctrl_axis_tlast(c_last), .s_ctrl_axis_tready(ctr0),
    .s_data_axis_tdata(d_data), .s_data_axis_tkeep(d_keep), .s_data_axis_tuser(d_user),
    .s_data_axis_tvalid(d_valid), .s_data_axis_tlast(d_last), .s_data_axis_tready(dtr0),
    .m_axis_tdata(m0_tdata), .m_axis_tkeep(m0_tkeep), .m_axis_tuser(m0_tuser),
    .m_axis_tvalid(m0_tvalid), .m_axis_tlast(m0_tlast), .m_axis_tready(m_tready),
    .cfg_busy(busy0), .ctrl_pkt_cnt(cc0), .data_pkt_cnt(dc0)
  );

  rmt_input_arbiter #(.CFG_GAP(0), .PKT_CNT_W(4)) u1 (
    .clk(clk), .aresetn(aresetn),
    .s_ctrl_axis_tdata(c_data), .s_ctrl_axis_tkeep(c_keep), .s_ctrl_axis_tuser(c_user),
    .s_ctrl_axis_tvalid(c_valid), .s_ctrl_axis_tlast(c_last), .s_ctrl_axis_tready(ctr1),
    .s_data_axis_tdata(d_data), .s_data_axis_tkeep(d_keep), .s_data_axis_tuser(d_user),
    .s_data_axis_tvalid(d_valid), .s_data_axis_tlast(d_last), .s_data_axis_tready(dtr1),
    .m_axis_tdata(m1_tdata), .m_axis_tkeep(m1_tkeep), .m_axis_tuser(m1_tuser),
    .m_axis_tvalid(m1_tvalid), .m_axis_tlast(m1_tlast), .m_axis_tready(m_tready),
    .cfg_busy(busy1), .ctrl_pkt_cnt(cc1), .data_pkt_cnt(dc1)
  );

  int vec = 0;
  int errs = 0;
  logic [8:0] log_q[$];

  // Beats accepted by u0's master port, as {tlast, tdata[7:0]}.
  always @(negedge clk) begin
    if (aresetn && m0_tvalid && m_tready) log_q.push_back({m0_tlast, m0_tdata[7:0]});
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    c_valid = 1'b0; c_last = 1'b0; c_data = '0; c_keep = '1; c_user = '0;
    d_valid = 1'b0; d_last = 1'b0; d_data = '0; d_keep = '1; d_user = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    aresetn = 1'b1;
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int busy_cycles;
    bit seen;
    logic [7:0] exp_ord [10];
    exp_ord = '{8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0D, 8'h0C, 8'h0C, 8'h0C, 8'h0C, 8'h0D};

    // Reset state, with inputs already active to show reset dominates.
    aresetn = 1'b0;
    c_valid = 1'b1; c_last = 1'b1; c_data = 512'h11; c_keep = '1; c_user = '0;
    d_valid = 1'b1; d_last = 1'b1; d_data = 512'h22; d_keep = '1; d_user = '0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl_tready", ctr0, 0);
    chk("rst_data_tready", dtr0, 0);
    chk("rst_m_tvalid", m0_tvalid, 0);
    chk("rst_cfg_busy", busy0, 0);
    chk("rst_ctrl_cnt", cc0, 0);
    chk("rst_data_cnt", dc0, 0);

    // Single 2-beat control packet through the default-gap arbiter.
    do_reset();
    c_valid = 1'b1; c_last = 1'b0; c_user = 128'h5A5A_0001;
    c_data = 512'(64'hffff_ffff_ffff_ffff);
    #1;
    chk("c1_idle_tready", ctr0, 0);
    chk("c1_idle_tvalid", m0_tvalid, 0);
    nxt();
    chk("c1_b0_tvalid", m0_tvalid, 1);
    chk("c1_b0_tdata", m0_tdata, 512'(64'hffff_ffff_ffff_ffff));
    chk("c1_b0_tuser", m0_tuser, 128'h5A5A_0001);
    chk("c1_b0_tkeep", m0_tkeep, {64{1'b1}});
    chk("c1_b0_tlast", m0_tlast, 0);
    chk("c1_b0_ctrl_tready", ctr0, 1);
    seen = dtr0;
    busy_cycles = busy0 ? 1 : 0;
    nxt();
    c_data = 512'(64'h0000_0000_000f_ffff); c_last = 1'b1;
    #1;
    chk("c1_b1_tdata", m0_tdata, 512'(64'h0000_0000_000f_ffff));
    chk("c1_b1_tlast", m0_tlast, 1);
    seen = seen | dtr0;
    if (busy0) busy_cycles++;
    nxt();
    c_valid = 1'b0; c_last = 1'b0;
    n = 0;
    while (busy0 && n < 40) begin
      seen = seen | dtr0;
      busy_cycles++;
      nxt();
      n++;
    end
    chk("c1_busy_cycles", busy_cycles, 10);
    chk("c1_data_tready_low", seen, 0);
    chk("c1_ctrl_cnt", cc0, 1);
    chk("c1_beats_out", log_q.size(), 2);

    // Both streams continuously valid, single-beat packets: burst limit order.
    do_reset();
    c_valid = 1'b1; c_last = 1'b1; c_data = 512'h0C;
    d_valid = 1'b1; d_last = 1'b1; d_data = 512'h0D;
    n = 0;
    while (log_q.size() < 10 && n < 400) begin
      nxt();
      n++;
    end
    c_valid = 1'b0; d_valid = 1'b0;
    chk("arb_count", log_q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("arb_order_%0d", i), log_q[i], {1'b1, exp_ord[i]});
    end
    nxt();
    chk("arb_ctrl_cnt", cc0, 8);
    chk("arb_data_cnt", dc0, 2);

    // 3-beat data packet with backpressure; control raised mid-packet is ignored.
    do_reset();
    d_valid = 1'b1; d_last = 1'b0; d_data = 512'hD1;
    c_data = 512'hC7; c_last = 1'b1;
    n = 0; seen = 1'b0;
    begin
      int idx;
      bit xfer;
      idx = 0;
      while (idx < 3 && n < 50) begin
        m_tready = (n % 2 == 0);
        if (n >= 1) c_valid = 1'b1;
        #1;
        seen = seen | ctr0;
        xfer = d_valid && dtr0;
        nxt();
        n++;
        if (xfer) begin
          idx++;
          d_data = 512'(8'hD1 + 8'(idx));
          d_last = (idx == 2);
          if (idx == 3) d_valid = 1'b0;
        end
      end
    end
    c_valid = 1'b0; m_tready = 1'b1;
    chk("dbp_ctrl_tready_low", seen, 0);
    chk("dbp_data_cnt", dc0, 1);
    chk("dbp_beats", log_q.size(), 3);
    chk("dbp_beat0", log_q[0], 9'h0D1);
    chk("dbp_beat1", log_q[1], 9'h0D2);
    chk("dbp_beat2", log_q[2], 9'h1D3);

    // No-gap arbiter: two back-to-back control packets, one idle cycle between.
    do_reset();
    c_valid = 1'b1; c_last = 1'b1; c_data = 512'hA5;
    #1;
    chk("g0_c0_busy", busy1, 0);
    nxt();
    chk("g0_c1_busy", busy1, 1);
    chk("g0_c1_tvalid", m1_tvalid, 1);
    chk("g0_c1_tready", ctr1, 1);
    nxt();
    chk("g0_c2_busy", busy1, 0);
    chk("g0_c2_tvalid", m1_tvalid, 0);
    nxt();
    chk("g0_c3_busy", busy1, 1);
    chk("g0_c3_tvalid", m1_tvalid, 1);
    nxt();
    c_valid = 1'b0;
    #1;
    chk("g0_c4_busy", busy1, 0);
    chk("g0_ctrl_cnt", cc1, 2);

    // Reset in the middle of a data packet, then a clean control packet.
    do_reset();
    d_valid = 1'b1; d_last = 1'b0; d_data = 512'hE1;
    nxt();
    nxt();
    d_data = 512'hE2;
    #1;
    aresetn = 1'b0;
    #1;
    chk("mid_rst_tvalid", m0_tvalid, 0);
    chk("mid_rst_tdata", m0_tdata, 0);
    chk("mid_rst_data_tready", dtr0, 0);
    chk("mid_rst_ctrl_tready", ctr0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_data_cnt", dc0, 0);
    nxt();
    d_valid = 1'b0;
    aresetn = 1'b1;
    log_q.delete();
    c_valid = 1'b1; c_last = 1'b0; c_data = 512'hF1;
    n = 0;
    while (!ctr0 && n < 20) begin
      nxt();
      n++;
    end
    nxt();
    c_data = 512'hF2; c_last = 1'b1;
    nxt();
    c_valid = 1'b0; c_last = 1'b0;
    #1;
    chk("post_rst_ctrl_cnt", cc0, 1);
    chk("post_rst_data_cnt", dc0, 0);
    chk("post_rst_beats", log_q.size(), 2);
    chk("post_rst_beat0", log_q[0], 9'h0F1);
    chk("post_rst_beat1", log_q[1], 9'h1F2);

    // Packet counter wrap on the narrow-counter instance.
    do_reset();
    d_last = 1'b1; d_data = 512'h77;
    for (int p = 0; p < 16; p++) begin
      d_valid = 1'b1;
      n = 0;
      while (!dtr1 && n < 20) begin
        nxt();
        n++;
      end
      nxt();
      d_valid = 1'b0;
      #1;
      if (p == 14) chk("wrap_at_max", dc1, 4'hF);
    end
    chk("wrap_to_zero", dc1, 0);
    chk("wrap_ctrl_cnt", cc1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
